// File: rtl/node_table_if.sv
// node_table_if: control, memory-bank and stream signals of the node table reader
interface node_table_if #(
  parameter int WORD_WIDTH = 16,
  parameter int IDX_WIDTH  = 6
);
  logic                  start;
  logic [IDX_WIDTH:0]    num_entries;
  logic                  mem_rd_en;
  logic [IDX_WIDTH-1:0]  mem_index;
  logic [WORD_WIDTH-1:0] mem_data;
  logic                  out_valid;
  logic                  out_ready;
  logic [IDX_WIDTH-1:0]  out_index;
  logic [WORD_WIDTH-1:0] out_data;
  logic                  busy;
  logic                  done;
  logic                  best_valid;
  logic [IDX_WIDTH-1:0]  best_index;
  logic [WORD_WIDTH-1:0] best_data;
  modport master (
    input  start, num_entries, mem_data, out_ready,
    output mem_rd_en, mem_index, out_valid, out_index, out_data,
           busy, done, best_valid, best_index, best_data
  );
  modport slave (
    output start, num_entries, mem_data, out_ready,
    input  mem_rd_en, mem_index, out_valid, out_index, out_data,
           busy, done, best_valid, best_index, best_data
  );
endinterface

// File: rtl/node_table_reader.sv
// node_table_reader: scans the node memory, streams non-empty entries and tracks the maximum
module node_table_reader #(
  parameter int WORD_WIDTH = 16,
  parameter int MEM_DEPTH  = 64,
  parameter int IDX_WIDTH  = 6
) (
  input logic        clk,
  input logic        rst,
  node_table_if.master bus
);
  typedef enum logic [2:0] {IDLE, READ, WAIT, HOLD, DONE} state_t;
  localparam logic [IDX_WIDTH:0] DEPTH = (IDX_WIDTH+1)'(MEM_DEPTH);
  state_t               state;
  logic [IDX_WIDTH-1:0] ptr;
  logic [IDX_WIDTH:0]   count;
  logic [IDX_WIDTH:0]   n_clamp;
  logic                 last;
  logic                 adv;
  assign n_clamp = bus.num_entries > DEPTH ? DEPTH : bus.num_entries;
  assign last = {1'b0, ptr} == count - 1'b1;
  assign adv = (state == WAIT && bus.mem_data == '0) || (state == HOLD && bus.out_ready);
  assign bus.mem_index = ptr;
  // scan sequencer: issue read, check word, hold it for the consumer, then advance or finish
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      ptr <= '0;
      count <= '0;
      bus.mem_rd_en <= 1'b0;
      bus.out_valid <= 1'b0;
      bus.out_index <= '0;
      bus.out_data <= '0;
      bus.busy <= 1'b0;
      bus.done <= 1'b0;
      bus.best_valid <= 1'b0;
      bus.best_index <= '0;
      bus.best_data <= '0;
    end else begin
      case (state)
        IDLE: if (bus.start) begin
          count <= n_clamp;
          ptr <= '0;
          bus.best_valid <= 1'b0;
          bus.best_index <= '0;
          bus.best_data <= '0;
          bus.busy <= n_clamp != '0;
          bus.done <= n_clamp == '0;
          bus.mem_rd_en <= n_clamp != '0;
          state <= n_clamp == '0 ? DONE : READ;
        end
        READ: begin
          bus.mem_rd_en <= 1'b0;
          state <= WAIT;
        end
        WAIT: if (bus.mem_data != '0) begin
          bus.out_valid <= 1'b1;
          bus.out_index <= ptr;
          bus.out_data <= bus.mem_data;
          state <= HOLD;
          if (!bus.best_valid || bus.mem_data > bus.best_data) begin
            bus.best_valid <= 1'b1;
            bus.best_index <= ptr;
            bus.best_data <= bus.mem_data;
          end
        end
        HOLD: if (bus.out_ready) bus.out_valid <= 1'b0;
        DONE: begin
          bus.done <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (adv) begin
        state <= last ? DONE : READ;
        ptr <= last ? ptr : ptr + 1'b1;
        bus.mem_rd_en <= !last;
        bus.done <= last;
        bus.busy <= !last;
      end
    end
  end
endmodule

// File: doc/node_table_reader.md
Name: node_table_reader

Overview:
- Read-side engine for the 64x16 node memory bank (clk, wr_en, index[5:0], data_in/data_out[15:0]).
- On a start pulse it walks entries 0..num_entries-1 and streams each non-empty word out over a valid/ready handshake.
- While walking, it tracks the largest entry value and its index, for neighbour/next-hop selection.
- Sits between the node memory bank and the routing/RL update logic; the writer side stays unchanged.

Parameters:
- WORD_WIDTH, 16, width of a memory word.
- MEM_DEPTH, 64, number of table entries.
- IDX_WIDTH, 6, index width, equal to log2(MEM_DEPTH).

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous active-high reset.
- start  in  1  one-cycle request to begin a scan; sampled in IDLE only.
- num_entries  in  IDX_WIDTH+1  entries to scan (0..64); latched on accepted start.
- mem_rd_en  out  1  read strobe to memory bank.
- mem_index  out  IDX_WIDTH  address to memory bank.
- mem_data  in  WORD_WIDTH  memory data_out.
- out_valid  out  1  out_index/out_data hold a valid entry.
- out_ready  in  1  consumer accepts the entry.
- out_index  out  IDX_WIDTH  index of the streamed entry.
- out_data  out  WORD_WIDTH  value of the streamed entry.
- busy  out  1  high from accepted start until the done cycle; low in the done cycle.
- done  out  1  one-cycle pulse at end of scan.
- best_valid  out  1  at least one non-zero entry was seen in the last scan.
- best_index  out  IDX_WIDTH  index of the maximum entry.
- best_data  out  WORD_WIDTH  maximum entry value.

Behaviour:
- Reset (synchronous, rst=1 at a clk edge):
  - All outputs go to 0, FSM goes to IDLE, internal pointer and count are cleared.
  - Applies mid-scan too: the scan is aborted, no done pulse, out_valid drops on that edge.
- FSM states: IDLE, READ, WAIT, HOLD, DONE.
- IDLE:
  - start=1 latches count = min(num_entries, 64), sets ptr=0, and clears best_*.
  - If count=0, go to DONE; otherwise go to READ.
  - busy=1 from the next cycle.
- READ: mem_rd_en=1 and mem_index=ptr for exactly one cycle, then WAIT. mem_index holds ptr in every other state; mem_rd_en=0 elsewhere.
- WAIT:
  - Memory read latency is 1 cycle, so mem_data is sampled at the end of WAIT.
  - mem_data=0 is an empty slot: skipped, not streamed, no best update, advance.
  - Non-zero: register out_index=ptr and out_data=mem_data, assert out_valid next cycle, go to HOLD.
  - Best update in the same edge: if best_valid=0 or mem_data > best_data (unsigned), load best_*. Ties keep the lower index.
- HOLD:
  - out_valid=1; out_index and out_data stay stable until out_valid && out_ready at a clk edge.
  - On transfer: out_valid=0 and advance.
  - out_ready while out_valid=0 is ignored.
- Advance: if ptr == count-1, go to DONE; otherwise ptr+1, then READ.
- Timing: minimum 2 cycles per empty entry, 3 per streamed entry with out_ready held high.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- best_* hold their values until the next accepted start or reset.
- start while busy is ignored. start in the DONE cycle is ignored.
- Index wraps never: the pointer never exceeds count-1 ≤ 63.

Test Plan:
- Reset: rst=1 for 2 cycles mid-scan (ptr=5, out_valid=1) -> next edge all outputs 0, FSM IDLE, no done pulse; a later start scans from index 0.
- Basic scan: mem[0]=3, mem[1]=0, mem[2]=15, num_entries=3, out_ready=1 ->
  - stream (0,3) then (2,15); index 1 is skipped.
  - done pulses once; best_index=2, best_data=15, best_valid=1.
- Backpressure: out_ready=0 for 5 cycles while entry (2,15) is valid -> out_valid, out_index and out_data are stable all 5 cycles; exactly one transfer when out_ready=1.
- Tie and max: mem[4]=200, mem[9]=200, mem[10]=7, num_entries=11 -> best_index=4, best_data=200.
- Empty/zero: num_entries=0 -> done the cycle after start, best_valid=0, no mem_rd_en. All-zero table with num_entries=64 -> no out_valid, best_valid=0, done after 128 cycles of scanning.
- Boundary/ignored start: num_entries=64 with mem[63]=9 only -> single transfer (63,9). start pulsed while busy -> no effect on count, ptr or stream.
